// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests at the current PC, buffers
// {pc, instr} in a small circular queue and presents the head to decode.
module fetch_unit #(
  parameter int N     = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    pc,
  output logic [N-1:0]    pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [N-1:0]    imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [N-1:0]    redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [N-1:0]    id_pc,
  output logic [ILEN-1:0] id_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]    q_pc     [DEPTH];
  logic [ILEN-1:0] q_instr  [DEPTH];
  logic [DEPTH-1:0] q_filled;

  logic [PW-1:0] head, tail, fill;
  // used: allocated entries; pend: allocated but not yet filled; drop: stale responses to discard
  logic [CW-1:0] used, pend, drop;

  logic [CW:0]   credit_sum;
  logic          fire, deq, rsp_drop, rsp_fill;
  logic [CW-1:0] drop_redir;

  always_comb begin
    credit_sum     = {1'b0, used} + {1'b0, drop};
    imem_req_valid = !redirect && (credit_sum < (CW+1)'(DEPTH));
    fire           = imem_req_valid && imem_req_ready;
    id_valid       = !redirect && (used != '0) && q_filled[head];
    deq            = id_valid && id_ready;
    rsp_drop       = imem_rsp_valid && (drop != '0);
    rsp_fill       = imem_rsp_valid && (drop == '0) && (pend != '0);
    // Every unfilled entry becomes a response to discard, less one already arriving now
    drop_redir     = drop + pend - CW'(rsp_drop) - CW'(rsp_fill);
    imem_req_addr  = pc;
    id_pc          = q_pc[head];
    id_instr       = q_instr[head];
  end

  always_comb begin
    pc_next = pc;
    if (redirect)
      pc_next = redirect_pc;
    else if (fire)
      pc_next = pc + N'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      used     <= '0;
      pend     <= '0;
      drop     <= '0;
      q_filled <= '0;
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      used     <= '0;
      pend     <= '0;
      drop     <= drop_redir;
      q_filled <= '0;
    end else begin
      if (fire) begin
        q_filled[tail] <= 1'b0;
        tail           <= tail + PW'(1);
      end
      if (rsp_fill) begin
        q_filled[fill] <= 1'b1;
        fill           <= fill + PW'(1);
      end
      if (deq) begin
        q_filled[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      used <= used + CW'(fire) - CW'(deq);
      pend <= pend + CW'(fire) - CW'(rsp_fill);
      drop <= drop - CW'(rsp_drop);
    end
  end

  // Payload storage needs no reset; validity lives in q_filled/used.
  always_ff @(posedge clk) begin
    if (fire)
      q_pc[tail] <= pc;
    if (rsp_fill)
      q_instr[fill] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC register and fixed-latency instruction memory models,
// a per-cycle vector table for stream/backpressure, and hand sequences for redirect/wrap/reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [63:0] pc_q;
  logic [63:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int inflight;

  fetch_unit #(.N(64), .ILEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc(pc_q), .pc_next(pc_next),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [63:0] a);
    return {8'hE0 ^ a[63:56], a[23:0]};
  endfunction

  // PC register
  always @(posedge clk or posedge rst)
    if (rst) pc_q <= '0;
    else     pc_q <= pc_next;

  // Instruction memory: fixed latency 1..3, in order, reset together with the core
  logic        mv0, mv1, mv2;
  logic [63:0] ma0, ma1, ma2;
  logic        mfire;
  assign mfire = imem_req_valid && imem_req_ready;
  always @(posedge clk or posedge rst)
    if (rst) begin
      mv0 <= 1'b0; mv1 <= 1'b0; mv2 <= 1'b0;
      ma0 <= '0;   ma1 <= '0;   ma2 <= '0;
    end else begin
      mv0 <= mfire; ma0 <= imem_req_addr;
      mv1 <= mv0;   ma1 <= ma0;
      mv2 <= mv1;   ma2 <= ma1;
    end
  assign imem_rsp_valid = (lat == 3) ? mv2 : (lat == 2) ? mv1 : mv0;
  assign imem_rsp_data  = memdata((lat == 3) ? ma2 : (lat == 2) ? ma1 : ma0);

  always @(posedge clk or posedge rst)
    if (rst) inflight <= 0;
    else     inflight <= inflight + (mfire ? 1 : 0) - (imem_rsp_valid ? 1 : 0);

  // A response with nothing outstanding (drop = 0 and no unfilled entry) is illegal
  always @(posedge clk)
    if (!rst && imem_rsp_valid)
      assert (inflight > 0) else $error("protocol violation: response with no request outstanding");

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic settle();
    #1;
    if (id_valid) chk("id_instr", {32'h0, id_instr}, {32'h0, memdata(id_pc)});
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1; lat = l;
    #1;
    chk("rst req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("rst id_valid", {63'h0, id_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        rst;
    logic        idr;
    logic        rr;
    logic        exp_req;
    logic [63:0] exp_pn;
    logic        exp_iv;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic idr, input logic rr, input logic ereq,
                     input logic [63:0] epn, input logic eiv, input logic [63:0] epc);
    vec_t v;
    v.rst = r; v.idr = idr; v.rr = rr; v.exp_req = ereq;
    v.exp_pn = epn; v.exp_iv = eiv; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0; imem_req_ready = 1'b0;

    // reset values
    add(1, 0, 0, 1, 64'h0, 0, 0);
    add(1, 0, 1, 1, 64'h4, 0, 0);
    // stream, 1-cycle memory, one instruction per cycle from cycle 2
    add(0, 1, 1, 1, 64'h4,  0, 0);
    add(0, 1, 1, 1, 64'h8,  0, 0);
    add(0, 1, 1, 1, 64'hC,  1, 64'h0);
    add(0, 1, 1, 1, 64'h10, 1, 64'h4);
    add(0, 1, 1, 1, 64'h14, 1, 64'h8);
    add(0, 1, 1, 1, 64'h18, 1, 64'hC);
    // reset, then decode stalled for 10 cycles
    add(1, 0, 1, 1, 64'h4,  0, 0);
    add(0, 0, 1, 1, 64'h4,  0, 0);
    add(0, 0, 1, 1, 64'h8,  0, 0);
    add(0, 0, 1, 1, 64'hC,  1, 64'h0);
    add(0, 0, 1, 1, 64'h10, 1, 64'h0);
    for (int k = 0; k < 6; k++) add(0, 0, 1, 0, 64'h10, 1, 64'h0);
    // release: full queue drains, fetch resumes at 0x10
    add(0, 1, 1, 0, 64'h10, 1, 64'h0);
    add(0, 1, 1, 1, 64'h14, 1, 64'h4);
    add(0, 1, 1, 1, 64'h18, 1, 64'h8);
    add(0, 1, 1, 1, 64'h1C, 1, 64'hC);
    add(0, 1, 1, 1, 64'h20, 1, 64'h10);
    add(0, 1, 1, 1, 64'h24, 1, 64'h14);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; id_ready = vecs[i].idr; imem_req_ready = vecs[i].rr;
      settle();
      chk($sformatf("row%0d req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].exp_req});
      chk($sformatf("row%0d pc_next", i), pc_next, vecs[i].exp_pn);
      chk($sformatf("row%0d id_valid", i), {63'h0, id_valid}, {63'h0, vecs[i].exp_iv});
      if (vecs[i].exp_iv) chk($sformatf("row%0d id_pc", i), id_pc, vecs[i].exp_pc);
    end

    // redirect with three requests in flight, 3-cycle memory; first stale response coincides
    do_reset(3);
    settle(); chk("rd3 c0 pc_next", pc_next, 64'h4);
    next(); settle();
    next(); settle(); chk("rd3 c2 pc_next", pc_next, 64'hC);
    next(); redirect = 1'b1; redirect_pc = 64'h100; settle();
    chk("rd3 redir req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rd3 redir id_valid", {63'h0, id_valid}, 64'h0);
    chk("rd3 redir pc_next", pc_next, 64'h100);
    next(); redirect = 1'b0; settle();
    chk("rd3 c4 req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("rd3 c4 pc_next", pc_next, 64'h104);
    chk("rd3 c4 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle(); chk("rd3 c5 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle(); chk("rd3 c6 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle(); chk("rd3 c7 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle();
    chk("rd3 c8 id_valid", {63'h0, id_valid}, 64'h1);
    chk("rd3 c8 id_pc", id_pc, 64'h100);
    next(); settle(); chk("rd3 c9 id_pc", id_pc, 64'h104);

    // redirect in the same cycle as the only outstanding response
    do_reset(1);
    settle();
    next(); redirect = 1'b1; redirect_pc = 64'h200; settle();
    chk("rdc redir id_valid", {63'h0, id_valid}, 64'h0);
    next(); redirect = 1'b0; settle();
    chk("rdc c2 pc_next", pc_next, 64'h204);
    chk("rdc c2 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle(); chk("rdc c3 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle();
    chk("rdc c4 id_valid", {63'h0, id_valid}, 64'h1);
    chk("rdc c4 id_pc", id_pc, 64'h200);
    next(); settle(); chk("rdc c5 id_pc", id_pc, 64'h204);

    // PC wrap at 2^64-4
    do_reset(1);
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; settle();
    chk("wrap redir pc_next", pc_next, 64'hFFFF_FFFF_FFFF_FFFC);
    next(); redirect = 1'b0; settle(); chk("wrap c1 pc_next", pc_next, 64'h0);
    next(); settle(); chk("wrap c2 pc_next", pc_next, 64'h4);
    next(); settle();
    chk("wrap c3 id_valid", {63'h0, id_valid}, 64'h1);
    chk("wrap c3 id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    next(); settle(); chk("wrap c4 id_pc", id_pc, 64'h0);

    // asynchronous reset mid-stream with two entries filled
    do_reset(1);
    id_ready = 1'b0; settle();
    next(); settle();
    next(); settle();
    next(); settle();
    chk("arst pre id_valid", {63'h0, id_valid}, 64'h1);
    chk("arst pre id_pc", id_pc, 64'h0);
    #2 rst = 1'b1;
    #1 chk("arst async id_valid", {63'h0, id_valid}, 64'h0);
    next(); rst = 1'b0; id_ready = 1'b1; settle();
    chk("arst c0 pc_next", pc_next, 64'h4);
    chk("arst c0 id_valid", {63'h0, id_valid}, 64'h0);
    next(); settle();
    next(); settle();
    chk("arst c2 id_valid", {63'h0, id_valid}, 64'h1);
    chk("arst c2 id_pc", id_pc, 64'h0);
    next(); settle(); chk("arst c3 id_pc", id_pc, 64'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
